// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide over WIDTH cycles, followed by a sign-fix cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     step_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;

        sign_a   = ~op[0] & inputA[WIDTH-1];
        sign_b   = ~op[0] & inputB[WIDTH-1];
        abs_a    = sign_a ? -inputA : inputA;
        abs_b    = sign_b ? -inputB : inputB;

        step_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff     = shifted - {1'b0, opnd_q};
        prod     = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && !op[2]) begin
                    state_d  = CALC;
                    cnt_d    = CNT_INIT;
                    acc_hi_d = '0;
                    is_div_d = op[1];
                    dz_d     = 1'b0;
                    if (!op[1]) begin
                        acc_lo_d = abs_b;
                        opnd_d   = abs_a;
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = 1'b0;
                    end else if (inputB == '0) begin
                        // Unsigned restoring divide by zero naturally leaves rem=dividend, quot=ones
                        acc_lo_d = inputA;
                        opnd_d   = '0;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                    end else begin
                        acc_lo_d = abs_a;
                        opnd_d   = abs_b;
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = sign_a;
                    end
                end else if (start && op == 3'b100) begin
                    hi_d = inputA;
                end else if (start && op == 3'b101) begin
                    lo_d = inputA;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!diff[WIDTH]) begin
                        acc_hi_d = diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = shifted[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {acc_hi_d, acc_lo_d} = {step_sum, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (is_div_q) begin
                    hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
                    lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
                    dz_d = (opnd_q == '0);
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
        end
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign divByZero = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard testbench for mul_div_unit: a 32-bit and an 8-bit instance checked
// against a plain-arithmetic reference model, with a decoupled monitor process.
module tb_mul_div_unit;
    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        int          e0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0;
    logic [7:0]  a1, b1;
    logic        busy0, done0, dz0;
    logic        busy1, done1, dz1;
    logic [31:0] hi0, lo0;
    logic [7:0]  hi1, lo1;

    exp_t sb0[$];
    exp_t sb1[$];
    int   lastE0[2];
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op0),
        .inputA(a0), .inputB(b0), .busy(busy0), .done(done0),
        .divByZero(dz0), .hi(hi0), .lo(lo0)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1),
        .inputA(a1), .inputB(b1), .busy(busy1), .done(done1),
        .divByZero(dz1), .hi(hi1), .lo(lo1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: sign-extend into 128-bit integers and use the language's own * / %
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [63:0] ain, input logic [63:0] bin);
        exp_t r;
        logic [63:0] mask, a, b;
        logic signed [127:0] x, y, p;
        logic [127:0] t;
        mask = (64'd1 << w) - 64'd1;
        a = ain & mask;
        b = bin & mask;
        r = '{hi: 64'd0, lo: 64'd0, dz: 1'b0, e0: 0};
        x = $signed({64'd0, a});
        y = $signed({64'd0, b});
        if (!op[0]) begin
            if (a[w-1]) x = x - (128'sd1 <<< w);
            if (b[w-1]) y = y - (128'sd1 <<< w);
        end
        if (!op[1]) begin
            p = x * y;
            t = p;
            r.lo = t[63:0] & mask;
            t = t >> w;
            r.hi = t[63:0] & mask;
        end else if (b == 64'd0) begin
            r.hi = a;
            r.lo = mask;
            r.dz = 1'b1;
        end else begin
            p = x / y;
            t = p;
            r.lo = t[63:0] & mask;
            p = x % y;
            t = p;
            r.hi = t[63:0] & mask;
        end
        return r;
    endfunction

    function automatic int qsize(input int idx);
        return (idx == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic [63:0] randOperand(input int w);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = 64'd1 << (w - 1);
            2: v = mask;
            3: v = 64'd1;
            4: v = 64'($urandom_range(0, 20));
            default: v = {32'($urandom), 32'($urandom)} & mask;
        endcase
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor step: busy/done windows from the pending expectation, result compare on done
    task automatic checkOutput(input int idx, input logic b, input logic d, input logic z,
                               input logic [63:0] h, input logic [63:0] l);
        exp_t f;
        bit   have;
        int   w;
        logic expB, expD;
        w = (idx == 0) ? 32 : 8;
        f = '{hi: 64'd0, lo: 64'd0, dz: 1'b0, e0: 0};
        have = (qsize(idx) != 0);
        if (have) f = (idx == 0) ? sb0[0] : sb1[0];
        expB = have && (cyc >= f.e0) && (cyc <= f.e0 + w);
        expD = have && (cyc == f.e0 + w + 1);
        checkValue($sformatf("dut%0d busy cyc%0d", w, cyc), 64'(b), 64'(expB));
        checkValue($sformatf("dut%0d done cyc%0d", w, cyc), 64'(d), 64'(expD));
        if (expD) begin
            checkValue($sformatf("dut%0d hi cyc%0d", w, cyc), h, f.hi);
            checkValue($sformatf("dut%0d lo cyc%0d", w, cyc), l, f.lo);
            checkValue($sformatf("dut%0d divByZero cyc%0d", w, cyc), 64'(z), 64'(f.dz));
            if (idx == 0) void'(sb0.pop_front());
            else void'(sb1.pop_front());
        end
    endtask

    always @(posedge clk) begin
        #1;
        checkOutput(0, busy0, done0, dz0, {32'd0, hi0}, {32'd0, lo0});
        checkOutput(1, busy1, done1, dz1, {56'd0, hi1}, {56'd0, lo1});
    end

    // Called at a negedge; holds start for one edge and returns at the following negedge
    task automatic applyStimulus(input int idx, input logic [2:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
        int   w, e;
        exp_t ex;
        w = (idx == 0) ? 32 : 8;
        e = cyc + 1;
        if (idx == 0) begin
            start0 = 1'b1; op0 = op; a0 = a[31:0]; b0 = b[31:0];
        end else begin
            start1 = 1'b1; op1 = op; a1 = a[7:0]; b1 = b[7:0];
        end
        if (!op[2] && (e >= lastE0[idx] + w + 2)) begin
            ex = model(w, op, a, b);
            ex.e0 = e;
            if (idx == 0) sb0.push_back(ex);
            else sb1.push_back(ex);
            lastE0[idx] = e;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitIdle(input int idx);
        int n;
        n = 0;
        while (qsize(idx) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkValue($sformatf("dut%0d drain", idx), 64'(qsize(idx)), 64'd0);
        if (idx == 0) sb0.delete();
        else sb1.delete();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        lastE0[0] = -1000;
        lastE0[1] = -1000;
        @(negedge clk);
        rst_n = 1'b1;
        checkValue("reset hi", 64'(hi0), 64'd0);
        checkValue("reset lo", 64'(lo0), 64'd0);
        checkValue("reset busy", 64'(busy0), 64'd0);
        checkValue("reset done", 64'(done0), 64'd0);
        checkValue("reset divByZero", 64'(dz0), 64'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] rop;
        rst_n = 1'b0;
        start0 = 1'b0; op0 = 3'd0; a0 = 32'd0; b0 = 32'd0;
        start1 = 1'b0; op1 = 3'd0; a1 = 8'd0; b1 = 8'd0;
        lastE0[0] = -1000;
        lastE0[1] = -1000;
        repeat (3) @(negedge clk);
        doReset();

        $display("[TB] signed/unsigned multiply");
        applyStimulus(0, 3'b000, 64'hFFFF_FFFD, 64'd5);
        waitIdle(0);
        applyStimulus(0, 3'b001, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        waitIdle(0);
        applyStimulus(0, 3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        waitIdle(0);

        $display("[TB] divide corner cases");
        applyStimulus(0, 3'b011, 64'd789, 64'd5);
        waitIdle(0);
        applyStimulus(0, 3'b010, 64'hFFFF_FFF9, 64'd2);
        waitIdle(0);
        applyStimulus(0, 3'b010, 64'h8000_0000, 64'hFFFF_FFFF);
        waitIdle(0);
        applyStimulus(0, 3'b011, 64'd85, 64'd0);
        waitIdle(0);
        applyStimulus(0, 3'b001, 64'd2, 64'd3);
        waitIdle(0);

        $display("[TB] start while busy, then back-to-back start in DONE");
        applyStimulus(0, 3'b000, 64'd7, 64'd7);
        repeat (9) @(negedge clk);
        applyStimulus(0, 3'b011, 64'd9, 64'd3);
        repeat (23) @(negedge clk);
        applyStimulus(0, 3'b001, 64'd1000, 64'd3000);
        waitIdle(0);

        $display("[TB] reset mid-divide, then MTHI/MTLO and no-op");
        applyStimulus(0, 3'b010, 64'd12345, 64'd67);
        repeat (14) @(negedge clk);
        doReset();
        repeat (40) @(negedge clk);
        applyStimulus(0, 3'b100, 64'd777, 64'd0);
        checkValue("mthi hi", 64'(hi0), 64'd777);
        applyStimulus(0, 3'b101, 64'd77, 64'd0);
        checkValue("mtlo lo", 64'(lo0), 64'd77);
        checkValue("mtlo hi kept", 64'(hi0), 64'd777);
        applyStimulus(0, 3'b110, 64'h1234, 64'h5678);
        applyStimulus(0, 3'b111, 64'h1234, 64'h5678);
        checkValue("noop hi", 64'(hi0), 64'd777);
        checkValue("noop lo", 64'(lo0), 64'd77);

        $display("[TB] randomized 32-bit operations");
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            applyStimulus(0, rop, randOperand(32), randOperand(32));
            if ($urandom_range(0, 1) == 1) repeat (33) @(negedge clk);
            else waitIdle(0);
        end
        waitIdle(0);

        $display("[TB] 8-bit instance");
        applyStimulus(1, 3'b000, 64'h80, 64'h80);
        waitIdle(1);
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 3));
            applyStimulus(1, rop, randOperand(8), randOperand(8));
            if ($urandom_range(0, 1) == 1) repeat (9) @(negedge clk);
            else waitIdle(1);
        end
        waitIdle(1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
